// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: owner encoding, master ids
// and the default starvation threshold.
package dmem_arbiter_pkg;

  // Lock owner of the shared memory port.
  typedef enum logic [1:0] {
    NONE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } owner_e;

  // Master identifiers used to tag a pending read return.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Consecutive denied m1 cycles before m1 is forced to win (legal 1..15).
  localparam int unsigned STARVE_MAX_DEF = 4;

  // Counter width wide enough for the largest legal threshold.
  localparam int unsigned CNT_W = 4;

endpackage : dmem_arbiter_pkg

// File: rtl/arb_starve_cnt.sv
// Saturating starvation counter for the low-priority master.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   inc        : requester denied this cycle
//   clr        : requester granted or idle this cycle (wins over inc)
//   sat        : count has reached MAX (registered)
module arb_starve_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority, increment holds at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_W'(MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count and saturation flag are registered together so sat is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      sat   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat   <= (cnt_d == CNT_W'(MAX));
    end
  end

endmodule : arb_starve_cnt

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data-memory port. m0 (CPU) has priority,
// m1 (UART DMA) is protected from starvation, and a lock bit lets either
// master hold the port across a read-modify-write sequence.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   mX_req/wr/lock/addr/wdata  : request from master X, held until mX_gnt
//   mX_gnt                     : access performed this cycle (combinational)
//   mX_rvalid/rdata            : read return, one cycle after the read grant
//   mem_rd/wr/addr/wdata       : shared memory port (combinational from grant)
//   mem_rdata                  : memory read data, valid the cycle after mem_rd
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e owner_q;
  owner_e owner_d;
  logic   req0;
  logic   req1;
  logic   starve_sat;
  logic   rd_pend_q;
  logic   rd_id_q;

  // Requests are masked while reset is held so every output reads 0.
  assign req0 = m0_req & reset;
  assign req1 = m1_req & reset;

  // Owner register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q <= NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Grant selection and next owner. A lock holder that stops requesting
  // still blocks the other master; starvation only matters in NONE.
  always_comb begin
    owner_d = owner_q;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    case (owner_q)
      OWN0: m0_gnt = req0;
      OWN1: m1_gnt = req1;
      default: begin
        owner_d = NONE;
        if (req0 && req1) begin
          m1_gnt = starve_sat;
          m0_gnt = ~starve_sat;
        end else begin
          m0_gnt = req0;
          m1_gnt = req1;
        end
      end
    endcase
    if (m0_gnt) begin
      owner_d = m0_lock ? OWN0 : NONE;
    end else if (m1_gnt) begin
      owner_d = m1_lock ? OWN1 : NONE;
    end
  end

  // m1 starvation tracking: counts denied cycles, cleared when idle or served.
  arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (req1 & ~m1_gnt),
    .clr   (~req1 | m1_gnt),
    .sat   (starve_sat)
  );

  // Shared memory port mux; idle port drives zeros.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_rd    = ~m0_wr;
      mem_wr    = m0_wr;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_rd    = ~m1_wr;
      mem_wr    = m1_wr;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Remember which master the in-flight read belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= M0;
    end else begin
      rd_pend_q <= mem_rd;
      if (mem_rd) begin
        rd_id_q <= m1_gnt ? M1 : M0;
      end
    end
  end

  // Read return steering: only the tagged master sees valid data.
  assign m0_rvalid = rd_pend_q & (rd_id_q == M0);
  assign m1_rvalid = rd_pend_q & (rd_id_q == M1);
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: m0 is the CPU load/store path and m1 is the UART DMA engine.
- Per cycle it selects one requester and drives the shared memory port, then routes read data back one cycle later.
- m0 has priority by default. A starvation counter guarantees m1 progress, and a lock input makes read-modify-write sequences atomic.
- Sits between the CPU datapath / peripheral DMA and the data memory. m0_req & ~m0_gnt is the CPU stall term.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive denied m1 request cycles after which m1 is forced to win (range 1..15).

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- m0_req  in  1  CPU requests access this cycle.
- m0_wr  in  1  1 = write, 0 = read.
- m0_lock  in  1  keep ownership after this grant.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  access performed this cycle.
- m0_rvalid  out  1  read data valid for m0.
- m0_rdata  out  DATA_W  read data.
- m1_req, m1_wr, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for the DMA.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_rd.

Behaviour:
- Reset values:
  - All outputs 0.
  - owner = NONE; starve_cnt = 0; rd_pend = 0.
- State machine (owner register):
  - NONE: no lock held.
  - OWN0: m0 holds lock.
  - OWN1: m1 holds lock.
- Grant selection (combinational, same cycle):
  - OWN0 and m0_req: grant m0.
  - OWN1 and m1_req: grant m1.
  - OWN0 / OWN1 with the owner not requesting: the other master is blocked; no grant.
  - NONE with only one master requesting: grant it.
  - NONE with both requesting: grant m1 if starve_cnt == STARVE_MAX, else grant m0.
- Exactly one or zero of m0_gnt and m1_gnt is high in any cycle.
- Memory port drive:
  - On grant, mem_addr and mem_wdata come from the winner; mem_rd = ~wr; mem_wr = wr.
  - With no grant: mem_rd = mem_wr = 0 and mem_addr/mem_wdata = 0.
- Request handshake:
  - A requester holds req, wr, addr and wdata stable until it sees gnt.
  - Each gnt is one complete transfer.
- Owner transitions (on clock):
  - Granted with lock = 1: owner becomes that master.
  - Granted with lock = 0: owner returns to NONE.
  - Owner deasserts req: owner stays.
  - A lock is released only by a granted access with lock = 0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) in any cycle where m1_req = 1 and m1_gnt = 0.
  - Clears to 0 on m1_gnt or when m1_req = 0.
  - A forced m1 win happens only in NONE; a lock by m0 takes precedence over starvation.
- Read return:
  - rd_pend and rd_id are registered on a read grant.
  - Next cycle: mX_rvalid = 1 for rd_id only, and mX_rdata = mem_rdata; otherwise rdata = 0.
  - Back-to-back reads to alternating masters each return in order, one per cycle.
- Simultaneous events:
  - A write grant in the cycle after a read does not disturb the read return.
  - A new grant and a return to the same master may overlap.
- Reset mid-operation:
  - A pending rvalid is dropped; no rvalid is issued after reset deasserts.
  - The lock is released.

Decomposition:
- Shared package holds:
  - Owner encoding: NONE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10.
  - Master id constants: M0 = 1'b0, M1 = 1'b1.
  - The STARVE_MAX default.
- One sub-module, arb_starve_cnt: saturating counter with inc, clr and sat outputs.
- Grant logic, the mux and read return stay in the top module.

Test Plan:
- Single requesters:
  - m0 read at addr 0x10, mem_rdata 0xDEADBEEF next cycle -> m0_gnt in cycle 0; m0_rvalid = 1 with m0_rdata = 0xDEADBEEF in cycle 1; m1 outputs stay 0.
  - m1 write 0x00000055 to 0x20 alone -> m1_gnt = 1, mem_wr = 1, mem_addr = 0x20, mem_wdata = 0x55 in the same cycle.
- Starvation: both request continuously for 10 cycles, STARVE_MAX = 4, no locks -> m0 granted in cycles 0-3 and m1 in cycle 4; the pattern repeats (m1 again in cycle 9).
- Lock: m0 granted with lock = 1 at 0x30, m0_req low for 2 cycles while m1_req high, then m0 write with lock = 0 -> m1_gnt stays 0 throughout; m1 is granted the cycle after m0's unlocking write.
- Alternating reads: m0 read, m1 read, m0 read in consecutive cycles, mem_rdata = 1, 2, 3 -> rvalid to m0, m1, m0 in cycles 1-3 with data 1, 2, 3.
- Reset mid-operation: reset low in the cycle after an m1 read grant -> m1_rvalid stays 0; owner = NONE and starve_cnt = 0 after release; the first cycle with only m0_req grants m0.
